// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative RV32M multiply/divide
//               unit: funct3 op codes, FSM state encoding, decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

  // Divide/remainder ops all have funct3[2] set
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Works on operand
//               magnitudes for 32 cycles (shift-add multiply or restoring
//               divide sharing one 64-bit accumulator), then applies sign
//               correction and divide-by-zero handling in a final cycle.
//               Fixed 33-cycle latency for every op.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      MD_Control,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MD_Result,
  output logic            Zero
);

  md_state_t               r_state;
  md_state_t               w_state_next;

  logic [2:0]              r_op;
  logic                    r_sign_a;
  logic                    r_sign_b;
  logic                    r_div0;
  logic [XLEN-1:0]         r_a_mag;
  logic [XLEN-1:0]         r_b_mag;
  logic [2*XLEN-1:0]       r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [XLEN-1:0]         r_result;
  logic                    r_done;

  // Operand capture: sign of each operand and its magnitude
  logic                    w_sa;
  logic                    w_sb;
  logic [XLEN-1:0]         w_a_mag;
  logic [XLEN-1:0]         w_b_mag;

  // Per-iteration datapath
  logic [XLEN:0]           w_mul_sum;
  logic [2*XLEN-1:0]       w_mul_next;
  logic [XLEN:0]           w_div_rem_sh;
  logic [XLEN:0]           w_div_sub;
  logic                    w_div_ge;
  logic [XLEN-1:0]         w_div_rem;
  logic [2*XLEN-1:0]       w_div_next;
  logic [2*XLEN-1:0]       w_acc_next;

  // Sign fix-up
  logic [2*XLEN-1:0]       w_prod;
  logic [XLEN-1:0]         w_quot;
  logic [XLEN-1:0]         w_rem;
  logic [XLEN-1:0]         w_a_orig;
  logic [XLEN-1:0]         w_fix_result;

  assign w_sa    = op_signed_a(MD_Control) & A[XLEN-1];
  assign w_sb    = op_signed_b(MD_Control) & B[XLEN-1];
  assign w_a_mag = w_sa ? (-A) : A;
  assign w_b_mag = w_sb ? (-B) : B;

  // Multiply: accumulator holds {partial product high, remaining multiplier};
  // add |B| when the multiplier LSB is set, then shift right one place.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_b_mag} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: accumulator holds {remainder, dividend/quotient}; shift left
  // into a 33-bit trial remainder, subtract |B| if it fits, shift in q bit.
  assign w_div_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge     = (w_div_rem_sh >= {1'b0, r_b_mag});
  assign w_div_sub    = w_div_rem_sh - {1'b0, r_b_mag};
  assign w_div_rem    = w_div_ge ? w_div_sub[XLEN-1:0] : w_div_rem_sh[XLEN-1:0];
  assign w_div_next   = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

  assign w_acc_next   = is_div(r_op) ? w_div_next : w_mul_next;

  assign w_prod   = (r_sign_a ^ r_sign_b) ? (-r_acc) : r_acc;
  assign w_quot   = (r_sign_a ^ r_sign_b) ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem    = r_sign_a ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
  // Original rs1 rebuilt from magnitude and sign, for REM by zero
  assign w_a_orig = r_sign_a ? (-r_a_mag) : r_a_mag;

  // Final result selection, including divide-by-zero results
  always_comb begin
    w_fix_result = '0;
    case (r_op)
      MD_MUL:                       w_fix_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix_result = r_div0 ? '1 : w_quot;
      MD_REM, MD_REMU:              w_fix_result = r_div0 ? w_a_orig : w_rem;
      default:                      w_fix_result = '0;
    endcase
  end

  // Next-state decode: IDLE -> CALC on start, 32 CALC cycles, one FIX cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(XLEN-1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: capture at start, iterate in CALC, load result in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= MD_Control;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_div0   <= (B == '0);
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign MD_Result = r_result;
  assign Zero      = (r_result == '0);

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, issued by the execute stage alongside the combinational `ALU` block. It handles the M-extension ops the single-cycle ALU cannot: `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM` and `REMU`. It accepts one operation per start pulse, stalls the pipeline via `busy`, and returns a 32-bit result with a one-cycle `done` pulse. The `Zero` flag has the same meaning as the ALU's.

## Interface
Parameters
- `XLEN`, 32: operand and result width; only 32 is supported.
- `CNT_W`, 5: iteration counter width, equal to log2(XLEN).

Ports
- `clk`: in, 1, the single clock; all logic is on the rising edge.
- `reset`: in, 1, synchronous, active-high.
- `start`: in, 1, launches an op; sampled only when not `busy`.
- `MD_Control`: in, 3, the instruction's funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`: in, XLEN, rs1 operand, captured at start.
- `B`: in, XLEN, rs2 operand, captured at start.
- `busy`: out, 1, high while an op is in flight.
- `done`: out, 1, one-cycle pulse when `MD_Result` becomes valid.
- `MD_Result`: out, XLEN, final result; holds its value until the next `done`.
- `Zero`: out, 1, `MD_Result == 0`, combinational from the output register.

## Operation
- States:
  - IDLE: on `start`, capture the op, |A|, |B| and the sign bits. Clear the counter. Go to CALC.
  - CALC: 32 iterations, counter 0..31. Leave for FIX when the counter is 31.
  - FIX: apply sign correction and special cases, load `MD_Result`, pulse `done`, return to IDLE.
- Signedness:
  - A is signed for MUL, MULH, MULHSU, DIV and REM.
  - B is signed for MUL, MULH, DIV and REM.
  - Otherwise the operand is treated as unsigned.
  - MUL's low word is identical either way.
- Multiply:
  - Shift-add on magnitudes into a 64-bit accumulator, one multiplier bit per CALC cycle.
  - In FIX, negate the 64-bit product if signA^signB.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring division on magnitudes: one quotient bit per CALC cycle, 33-bit partial remainder.
  - In FIX, negate the quotient if signA^signB, and negate the remainder if signA.
- Divide by zero, detected at start and applied in FIX:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return the original A.
  - Latency is unchanged.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF) yields 0x80000000; the matching REM yields 0. The magnitude path produces this naturally; no special case is added.
- `start` while `busy` is ignored, and operands are not re-captured.
- A/B/MD_Control changes after the start edge have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `MD_Result`=0, so `Zero`=1. All internal registers are cleared.
- `reset` mid-op: the op is abandoned on the next edge; no `done` is issued and `MD_Result` becomes 0.
- Latency: `start` is sampled at edge E0. `busy`=1 after E0. CALC runs across edges E1..E32 and FIX completes at E33. After E33, `done`=1 for one cycle, `busy`=0 and `MD_Result` is valid. Fixed latency is 33 cycles for every op.
- Back-to-back: `start` may be asserted in the same cycle as `done`. It is sampled at E33+1, giving one op per 34 cycles.
- `done` and `busy` are never high together.

## Structure
- Package `muldiv_pkg` holds:
  - the funct3 op localparams (MD_MUL … MD_REMU);
  - the state encoding (IDLE, CALC, FIX);
  - an `is_div` decode helper (MD_Control[2]).
- Single module. No sub-module is needed; the multiply and divide datapaths share the accumulator and counter registers.

## Test plan
- MUL with A=0xFFFFFFFE (-2), B=3: `done` 33 cycles after start, `MD_Result`=0xFFFFFFFA.
- MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF: results 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV/REM with A=-7, B=2: DIV gives 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1), `Zero`=0.
- DIVU/REMU with B=0 and A=0x12345678: DIVU gives 0xFFFFFFFF; REMU gives 0x12345678.
- DIV 0x80000000 by 0xFFFFFFFF gives 0x80000000; REM gives 0 with `Zero`=1.
- Assert `reset` at CALC cycle 10 → next cycle `busy`=0, `MD_Result`=0, no `done` pulse. Also, a second `start` pulse during `busy` is ignored and only one `done` appears.
